// File: rtl/hist_dump_pkg.sv
// Shared types and constants for the histogram readout engine.
package hist_dump_pkg;

  typedef enum logic [2:0] {IDLE, HDR, BINS, DRAIN, CLEAR} state_t;

  localparam int          HDR_WORDS     = 9;
  localparam logic [31:0] MAGIC_DEFAULT = 32'h4C48_5354;

  localparam logic [3:0] HDR_MAGIC    = 4'd0;
  localparam logic [3:0] HDR_SAMPLES  = 4'd1;
  localparam logic [3:0] HDR_OVERFLOW = 4'd2;
  localparam logic [3:0] HDR_MIN_LO   = 4'd3;
  localparam logic [3:0] HDR_MIN_HI   = 4'd4;
  localparam logic [3:0] HDR_MAX_LO   = 4'd5;
  localparam logic [3:0] HDR_MAX_HI   = 4'd6;
  localparam logic [3:0] HDR_SUM_LO   = 4'd7;
  localparam logic [3:0] HDR_SUM_HI   = 4'd8;
  localparam logic [3:0] HDR_LAST     = 4'(HDR_WORDS - 1);

endpackage

// File: rtl/stream_skid_buf.sv
// 2-entry stream buffer with synchronous flush; accepts a push while full
// only if the head is popped in the same cycle. Head is stable until popped.
module stream_skid_buf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic [1:0]   level,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign pop_valid = (level != 2'd0);
  assign pop_data  = mem[rd_ptr];
  assign do_pop    = pop_valid & pop_ready;
  assign do_push   = push & ((level != 2'd2) | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      level  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      level  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      level <= level + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/hist_dump_engine.sv
// Histogram readout master: snapshots stats, reads every bin, streams one
// framed record (header + bins) and optionally clears the histogram.
module hist_dump_engine
  import hist_dump_pkg::*;
#(
  parameter int          HIST_BINS = 256,
  parameter logic [31:0] MAGIC     = MAGIC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        cfg_clear_on_read,
  output logic        busy,
  output logic        done,
  output logic [7:0]  hist_addr,
  output logic        hist_rd,
  input  logic [31:0] hist_data,
  output logic        hist_clear,
  input  logic [31:0] stat_samples,
  input  logic [31:0] stat_overflow,
  input  logic [63:0] stat_min_latency,
  input  logic [63:0] stat_max_latency,
  input  logic [63:0] stat_sum_latency,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last
);

  localparam int AW = $clog2(HIST_BINS);

  state_t        state;
  logic [3:0]    hdr_idx;
  logic [AW-1:0] bin_cnt;
  logic          rd_q;
  logic          last_q;
  logic [31:0]   snap_samples;
  logic [31:0]   snap_overflow;
  logic [63:0]   snap_min;
  logic [63:0]   snap_max;
  logic [63:0]   snap_sum;
  logic [1:0]    level;
  logic [1:0]    lvl_eff;
  logic [2:0]    lvl_next;
  logic          pop;
  logic          hdr_push;
  logic          push;
  logic          bin_last;
  logic [31:0]   hdr_word;
  logic [32:0]   push_data;
  logic [32:0]   buf_out;

  // Occupancy counts this cycle's pop so a full-rate stream keeps reading.
  assign pop      = m_valid & m_ready;
  assign lvl_eff  = level - {1'b0, pop};
  assign hdr_push = (state == HDR) && (lvl_eff != 2'd2);
  assign push     = hdr_push | rd_q;
  assign lvl_next = {1'b0, lvl_eff} + {2'b00, push};
  assign bin_last = (bin_cnt == AW'(HIST_BINS - 1));

  // The first bin read overlaps the last header push so the record is gapless.
  assign hist_rd   = !abort && (lvl_next < 3'd2) &&
                     ((state == BINS) || (state == HDR && hdr_idx == HDR_LAST && hdr_push));
  assign hist_addr = 8'(bin_cnt);

  always_comb begin
    hdr_word = 32'd0;
    case (hdr_idx)
      HDR_MAGIC:    hdr_word = MAGIC;
      HDR_SAMPLES:  hdr_word = snap_samples;
      HDR_OVERFLOW: hdr_word = snap_overflow;
      HDR_MIN_LO:   hdr_word = snap_min[31:0];
      HDR_MIN_HI:   hdr_word = snap_min[63:32];
      HDR_MAX_LO:   hdr_word = snap_max[31:0];
      HDR_MAX_HI:   hdr_word = snap_max[63:32];
      HDR_SUM_LO:   hdr_word = snap_sum[31:0];
      HDR_SUM_HI:   hdr_word = snap_sum[63:32];
      default:      hdr_word = 32'd0;
    endcase
  end

  assign push_data = hdr_push ? {1'b0, hdr_word} : {last_q, hist_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      hist_clear    <= 1'b0;
      hdr_idx       <= 4'd0;
      bin_cnt       <= '0;
      rd_q          <= 1'b0;
      last_q        <= 1'b0;
      snap_samples  <= 32'd0;
      snap_overflow <= 32'd0;
      snap_min      <= 64'd0;
      snap_max      <= 64'd0;
      snap_sum      <= 64'd0;
    end else begin
      done       <= 1'b0;
      hist_clear <= 1'b0;
      rd_q       <= hist_rd;
      last_q     <= bin_last;
      if (abort) begin
        state   <= IDLE;
        busy    <= 1'b0;
        rd_q    <= 1'b0;
        hdr_idx <= 4'd0;
        bin_cnt <= '0;
      end else begin
        case (state)
          IDLE: if (start) begin
            snap_samples  <= stat_samples;
            snap_overflow <= stat_overflow;
            snap_min      <= stat_min_latency;
            snap_max      <= stat_max_latency;
            snap_sum      <= stat_sum_latency;
            busy          <= 1'b1;
            hdr_idx       <= 4'd0;
            bin_cnt       <= '0;
            state         <= HDR;
          end
          HDR: begin
            if (hdr_push) hdr_idx <= hdr_idx + 4'd1;
            if (hdr_push && hdr_idx == HDR_LAST) state <= BINS;
            if (hist_rd) bin_cnt <= bin_cnt + AW'(1);
          end
          BINS: if (hist_rd) begin
            bin_cnt <= bin_cnt + AW'(1);
            if (bin_last) state <= DRAIN;
          end
          DRAIN: if (pop && m_last) begin
            done       <= 1'b1;
            busy       <= 1'b0;
            hist_clear <= cfg_clear_on_read;
            state      <= cfg_clear_on_read ? CLEAR : IDLE;
          end
          CLEAR:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  stream_skid_buf #(.W(33)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .push      (push),
    .push_data (push_data),
    .level     (level),
    .pop_valid (m_valid),
    .pop_ready (m_ready),
    .pop_data  (buf_out)
  );

  assign m_last = buf_out[32];
  assign m_data = buf_out[31:0];

endmodule
